// File: rtl/usb_serial_pkg.sv
// Shared types and defaults for the USB serial IN-endpoint scheduler.
package usb_serial_pkg;

  localparam int MAX_PKT_DEFAULT      = 64;
  localparam int FLUSH_CYCLES_DEFAULT = 48000;
  localparam int TIMER_W              = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE,
    ST_WAIT_ACK
  } state_e;

endpackage

// File: rtl/usb_idle_timer.sv
// Saturating idle counter; expired flags the cycle the count reaches COUNT and stays up while it holds there.
module usb_idle_timer
  import usb_serial_pkg::*;
#(
  parameter logic [TIMER_W-1:0] COUNT = TIMER_W'(FLUSH_CYCLES_DEFAULT - 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != COUNT)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Expiry looks at the value being loaded, so the owner reacts on the cycle the count is reached.
  assign expired = enable && !clear && (count_d == COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/usb_serial_in_sched.sv
// Moves bytes from a show-ahead tx FIFO into USB IN packets, closing on full, idle flush or SOF, with ZLP after full packets.
module usb_serial_in_sched
  import usb_serial_pkg::*;
#(
  parameter int MAX_PKT      = MAX_PKT_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_avail,
  output logic       fifo_pop,
  input  logic       sof_valid,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked,
  output logic       busy
);

  localparam logic [6:0]         MAX_CNT  = 7'(MAX_PKT);
  localparam logic [TIMER_W-1:0] FLUSH_TC = TIMER_W'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [6:0] byte_cnt_q, byte_cnt_d;
  logic       zlp_pend_q, zlp_pend_d;
  logic       put;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_expired;

  // The put is combinational on the FIFO head so a byte moves on the same cycle it is seen.
  assign put = (state_q == ST_FILL) && in_ep_grant && in_ep_data_free && fifo_avail
               && (byte_cnt_q < MAX_CNT);

  assign timer_en    = (state_q == ST_FILL);
  assign timer_clear = (state_q != ST_FILL) || put;

  usb_idle_timer #(
    .COUNT(FLUSH_TC)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    zlp_pend_d = zlp_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_avail || zlp_pend_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (in_ep_grant && in_ep_data_free) begin
          state_d    = ST_FILL;
          byte_cnt_d = '0;
        end
      end
      ST_FILL: begin
        if (put) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          zlp_pend_d = 1'b0;
        end
        // A single close decision covers full, flush and SOF together, so coincident causes give one DONE.
        if ((put && (byte_cnt_d == MAX_CNT)) || (!fifo_avail && (timer_expired || sof_valid))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        zlp_pend_d = (byte_cnt_q == MAX_CNT);
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (in_ep_acked) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      zlp_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      zlp_pend_q <= zlp_pend_d;
    end
  end

  assign fifo_pop        = put;
  assign in_ep_data_put  = put;
  assign in_ep_data      = put ? fifo_data : 8'h00;
  assign in_ep_data_done = (state_q == ST_DONE);
  assign in_ep_req       = (state_q != ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign in_ep_stall     = 1'b0;

endmodule

// File: doc/usb_serial_in_sched.md
USB_SERIAL_IN_SCHED -- requirements
Module: usb_serial_in_sched

Interface
REQ-001 Parameter MAX_PKT, default 64, SHALL set the maximum IN packet payload in bytes (1..64).
REQ-002 Parameter FLUSH_CYCLES, default 48000, SHALL set the idle clk cycles before a partial packet is closed (16-bit).
REQ-003 clk  in  1  single clock; all logic is on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fifo_data  in  8  head byte of the upstream show-ahead tx FIFO; valid when fifo_avail=1.
REQ-006 fifo_avail  in  1  upstream FIFO non-empty.
REQ-007 fifo_pop  out  1  consume the head byte this cycle.
REQ-008 sof_valid  in  1  USB start-of-frame pulse.
REQ-009 in_ep_req / in_ep_grant  out / in  1 / 1  endpoint buffer request and grant to/from the protocol engine.
REQ-010 in_ep_data_free  in  1  engine buffer can accept a byte.
REQ-011 in_ep_data_put / in_ep_data  out / out  1 / 8  byte write strobe and byte.
REQ-012 in_ep_data_done  out  1  one-cycle pulse that closes the packet.
REQ-013 in_ep_stall  out  1  constant 0.
REQ-014 in_ep_acked  in  1  host ACKed the last packet.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL use states IDLE, REQ, FILL, DONE and WAIT_ACK, plus a byte counter byte_cnt (7 bits), an idle timer and a flag zlp_pend.
REQ-017 IDLE: if fifo_avail=1 or zlp_pend=1, SHALL move to REQ on the next cycle.
REQ-018 REQ, FILL, DONE and WAIT_ACK: in_ep_req SHALL be 1.
REQ-019 REQ: when in_ep_grant=1 and in_ep_data_free=1, SHALL go to FILL, clear byte_cnt and clear the idle timer.
REQ-020 FILL: the put condition is grant, data_free and fifo_avail all 1 and byte_cnt<MAX_PKT.
REQ-021 When the put condition holds, fifo_pop, in_ep_data_put and in_ep_data=fifo_data SHALL be driven combinationally in the same cycle (zero latency), and byte_cnt SHALL increment.
REQ-022 FILL: the idle timer SHALL clear on each put and increment on every other cycle.
REQ-023 FILL SHALL go to DONE on the first cycle any of these holds:
- byte_cnt reaches MAX_PKT, including the cycle of the MAX_PKT-th put;
- the idle timer reaches FLUSH_CYCLES-1 with fifo_avail=0;
- sof_valid=1 with fifo_avail=0.
REQ-024 FILL: when grant or data_free is 0, there SHALL be no put or pop, and state, byte_cnt and byte order SHALL be preserved.
REQ-025 DONE: in_ep_data_done SHALL be 1 for exactly one cycle, zlp_pend SHALL be set to (byte_cnt==MAX_PKT), and the FSM SHALL go to WAIT_ACK.
REQ-026 WAIT_ACK: no puts; on in_ep_acked=1 SHALL go to IDLE with in_ep_req deasserted in the following cycle.
REQ-027 ZLP: with zlp_pend=1 and fifo_avail=0 at FILL entry, the FSM SHALL wait FLUSH_CYCLES (or sof_valid) and then close a 0-byte packet.
REQ-028 ZLP: any byte arriving before that flush SHALL clear zlp_pend and start a normal packet.
REQ-029 sof_valid and the MAX_PKT-th put in the same cycle SHALL produce one DONE, not two.
REQ-030 byte_cnt SHALL never exceed MAX_PKT, and no pop SHALL occur outside FILL.

Reset
REQ-031 When reset=0, the block SHALL asynchronously enter IDLE and clear byte_cnt, the idle timer and zlp_pend.
REQ-032 When reset=0, all outputs SHALL be 0, including mid-packet.
REQ-033 After release, the first packet SHALL start from byte_cnt=0; bytes already put are owned by the engine and are not replayed.

Structure
REQ-034 A shared package usb_serial_pkg SHALL hold:
- the state enum;
- the MAX_PKT default (64) and the FLUSH_CYCLES default (48000);
- the timer width constant (16).
REQ-035 The idle timer SHALL be one sub-module, usb_idle_timer (inputs clear and enable; output expired at the programmed count). All other logic SHALL be in-module.

Verification
REQ-036 Push 0x41,0x42,0x43 then idle: one packet of 3 bytes in order, data_done exactly FLUSH_CYCLES after the last put; after acked, req=0 and busy=0.
REQ-037 Push 64 bytes back-to-back: 64 puts, data_done the cycle after the 64th put; after acked, a 0-byte packet (data_done with no puts) follows FLUSH_CYCLES later.
REQ-038 Push 100 bytes: packets of 64 and 36 bytes, no ZLP, 100 pops in total.
REQ-039 Drop data_free for 5 cycles after 10 bytes: no put or pop during the gap; the sequence then resumes at byte 11 unchanged.
REQ-040 After 5 bytes with FIFO empty, pulse sof_valid: data_done on the next cycle, packet length 5.
REQ-041 Assert reset in FILL after 10 bytes: all outputs 0 in the same cycle. After release with 3 bytes queued: new packet of 3 bytes with byte_cnt starting at 0.
